// File: rtl/button_direction_input.sv
// button_direction_input
//
// Input conditioner for the four game keys. Each raw active-low KEY pin is
// brought into the clk domain through a two-flop synchroniser, debounced,
// and edge-detected. A pending movement direction is latched from the
// lowest-index key press and held until the game loop consumes it.
//
// Direction encoding (matches the player path):
//   0 = +x (key 0), 1 = +y (key 1), 2 = -x (key 2), 3 = -y (key 3)
//
// Optional feature: define DIR_AUTO_REPEAT_EN to build per-key auto-repeat.
// While a key stays held, it re-arms the direction every REPEAT_CYCLES
// cycles. Without the macro, only press edges set dir_valid.
//
// Parameters:
//   DEBOUNCE_CYCLES  number of stable cycles before a synced level change is
//                    accepted (>= 1)
//   REPEAT_CYCLES    auto-repeat period while a key is held (>= 1). Used only
//                    with DIR_AUTO_REPEAT_EN.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-low reset
//   btn_n[3:0]   raw keys, 0 = pressed, asynchronous to clk
//   consume      one-cycle pulse from the game loop: pending direction taken
//   held[3:0]    debounced level per key, 1 = pressed
//   press_pulse  one-cycle pulse per key on a debounced press
//   dir_valid    a direction is pending
//   dir[1:0]     pending direction, meaningful while dir_valid = 1

module button_direction_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    input  logic       consume,
    output logic [3:0] held,
    output logic [3:0] press_pulse,
    output logic       dir_valid,
    output logic [1:0] dir
);

    // A one-cycle debounce window still needs a 1-bit counter.
    localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("button_direction_input: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser. Both stages reset to 1, which is "released"
    // on the active-low pins.
    // ------------------------------------------------------------------
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg <= 4'b1111;
            sync2_reg <= 4'b1111;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
        end
    end

    // Invert after the second stage so 1 = pressed from here on.
    assign sync = ~sync2_reg;

    // Sources that may set the pending direction: press edges, plus
    // auto-repeat ticks when that feature is built.
    logic [3:0] dir_src;

`ifdef DIR_AUTO_REPEAT_EN
    localparam int              RP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);
    logic [3:0] repeat_pulse;
`endif

    // ------------------------------------------------------------------
    // Per-key debounce and press detection.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            logic [DB_W-1:0] db_cnt_reg;
            logic            held_reg;
            logic            press_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    db_cnt_reg <= '0;
                    held_reg   <= 1'b0;
                    press_reg  <= 1'b0;
                end else begin
                    press_reg <= 1'b0;
                    if (sync[gi] == held_reg) begin
                        // Input agrees with the accepted level: any bounce
                        // in progress is discarded.
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        held_reg   <= sync[gi];
                        db_cnt_reg <= '0;
                        // Pulse coincides with the first cycle held reads 1;
                        // releases do not pulse.
                        press_reg  <= sync[gi];
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
            end

            assign held[gi]        = held_reg;
            assign press_pulse[gi] = press_reg;

`ifdef DIR_AUTO_REPEAT_EN
            logic [RP_W-1:0] rp_cnt_reg;
            logic            rp_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rp_cnt_reg <= '0;
                    rp_reg     <= 1'b0;
                end else begin
                    rp_reg <= 1'b0;
                    // The press itself already set the direction, so the
                    // repeat period starts counting from the press pulse.
                    if (!held_reg || press_reg) begin
                        rp_cnt_reg <= '0;
                    end else if (rp_cnt_reg == RP_LAST) begin
                        rp_cnt_reg <= '0;
                        rp_reg     <= 1'b1;
                    end else begin
                        rp_cnt_reg <= rp_cnt_reg + 1'b1;
                    end
                end
            end

            assign repeat_pulse[gi] = rp_reg;
            assign dir_src[gi]      = press_reg | rp_reg;
`else
            assign dir_src[gi]      = press_reg;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lowest set bit of dir_src wins when several keys fire together.
    // ------------------------------------------------------------------
    logic [1:0] dir_sel;

    always_comb begin
        dir_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (dir_src[i]) begin
                dir_sel = 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending direction latch. A new press always wins over a consume in
    // the same cycle, and overwrites an unconsumed direction.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            dir_valid <= 1'b0;
            dir       <= 2'd2;   // game loop starts moving -x
        end else if (|dir_src) begin
            dir       <= dir_sel;
            dir_valid <= 1'b1;
        end else if (consume && dir_valid) begin
            dir_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_direction_input.sv
// tb_button_direction_input
//
// Scoreboard bench for button_direction_input with DEBOUNCE_CYCLES = 4 and
// REPEAT_CYCLES = 10. The stimulus process drives directed key patterns and
// pushes the hand-computed output events (held change, press pulse,
// dir_valid/dir change) tagged with the cycle at which each must appear.
// A monitor samples the DUT on every falling edge, turns what it sees into
// events and matches them against the queue.
//
// Ports: none (top-level bench).

module tb_button_direction_input;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_n;
    logic       consume;
    logic [3:0] held;
    logic [3:0] press_pulse;
    logic       dir_valid;
    logic [1:0] dir;

    button_direction_input #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .consume    (consume),
        .held       (held),
        .press_pulse(press_pulse),
        .dir_valid  (dir_valid),
        .dir        (dir)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; read on falling edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event kinds: 0 = held changed, 1 = press pulse seen, 2 = {dir_valid,dir}
    // changed. D values are packed as {1'b0, dir_valid, dir}.
    typedef struct {
        int         kind;
        logic [3:0] val;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];

    int checks = 0;
    int errors = 0;

    bit         mon_en = 1'b0;
    logic [3:0] prev_held;
    logic [3:0] prev_d;
    ev_t        mon_e;

    function automatic string kname(input int kind);
        case (kind)
            0:       return "held";
            1:       return "press_pulse";
            default: return "dir";
        endcase
    endfunction

    // Insert keeping the queue ordered by cycle, then by kind.
    task automatic expect_ev(input int kind, input logic [3:0] val, input int c);
        ev_t e;
        int  idx;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        idx    = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc > c || (exp_q[i].cyc == c && exp_q[i].kind > kind)) begin
                idx = i;
                break;
            end
        end
        exp_q.insert(idx, e);
    endtask

    task automatic check_ev(input int kind, input logic [3:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got %b at cycle %0d, required no event",
                     kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                errors++;
                $display("FAIL event_%s: got %s=%b at cycle %0d, required %s=%b at cycle %0d",
                         kname(kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
            end else begin
                $display("event %s=%b at cycle %0d ok", kname(kind), val, cyc);
            end
        end
    endtask

    // Monitor: expired expectations are misses, then observed events are
    // matched in held / press / dir order.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_%s: got nothing, required %b at cycle %0d",
                         kname(mon_e.kind), mon_e.val, mon_e.cyc);
            end
            if (held !== prev_held) begin
                check_ev(0, held);
                prev_held = held;
            end
            if (press_pulse !== 4'b0000) begin
                check_ev(1, press_pulse);
            end
            if ({1'b0, dir_valid, dir} !== prev_d) begin
                check_ev(2, {1'b0, dir_valid, dir});
                prev_d = {1'b0, dir_valid, dir};
            end
        end
    end

    task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end else begin
            $display("check %s: %b ok", name, act);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // One-cycle consume; optionally expect the resulting dir event next edge.
    task automatic consume_pulse(input bit change, input logic [3:0] dexp);
        if (change) expect_ev(2, dexp, cyc + 1);
        consume = 1'b1;
        @(negedge clk);
        consume = 1'b0;
    endtask

    int n;

    initial begin
        rst     = 1'b0;
        btn_n   = 4'b0000;
        consume = 1'b0;

        // Reset with all keys held low: outputs stay at reset values.
        repeat (3) @(negedge clk);
        check_val("reset_held", held, 4'b0000);
        check_val("reset_press", press_pulse, 4'b0000);
        check_val("reset_dir_valid", {3'b000, dir_valid}, 4'b0000);
        check_val("reset_dir", {2'b00, dir}, 4'b0010);
        prev_held = 4'b0000;
        prev_d    = 4'b0010;
        mon_en    = 1'b1;
        @(negedge clk);
        check_val("reset_held_still", held, 4'b0000);
        check_val("reset_dir_still", {1'b0, dir_valid, dir}, 4'b0010);

        // All four keys pressed through reset release.
        n = cyc;
        rst = 1'b1;
        expect_ev(0, 4'b1111, n + 6);
        expect_ev(1, 4'b1111, n + 6);
        expect_ev(2, 4'b0100, n + 7);
        wait_until(n + 7);
        btn_n = 4'b1111;
        expect_ev(0, 4'b0000, n + 13);
        wait_until(n + 14);
        consume_pulse(1'b1, 4'b0000);

        // Key 1 press, then consume keeps dir = 1.
        wait_until(n + 17);
        n = cyc;
        btn_n = 4'b1101;
        expect_ev(0, 4'b0010, n + 6);
        expect_ev(1, 4'b0010, n + 6);
        expect_ev(2, 4'b0101, n + 7);
        wait_until(n + 7);
        btn_n = 4'b1111;
        expect_ev(0, 4'b0000, n + 13);
        wait_until(n + 9);
        consume_pulse(1'b1, 4'b0001);
        wait_until(n + 16);

        // Key 2 bounce: low 3 / high 1 / low 3 / high, never accepted.
        btn_n = 4'b1011;
        repeat (3) @(negedge clk);
        btn_n = 4'b1111;
        @(negedge clk);
        btn_n = 4'b1011;
        repeat (3) @(negedge clk);
        btn_n = 4'b1111;
        repeat (10) @(negedge clk);
        check_val("bounce_held", held, 4'b0000);
        check_val("bounce_dir", {1'b0, dir_valid, dir}, 4'b0001);

        // Key 3 pending, overwritten by key 0 (last press wins).
        n = cyc;
        btn_n = 4'b0111;
        expect_ev(0, 4'b1000, n + 6);
        expect_ev(1, 4'b1000, n + 6);
        expect_ev(2, 4'b0111, n + 7);
        wait_until(n + 7);
        btn_n = 4'b1111;
        expect_ev(0, 4'b0000, n + 13);
        wait_until(n + 15);
        n = cyc;
        btn_n = 4'b1110;
        expect_ev(0, 4'b0001, n + 6);
        expect_ev(1, 4'b0001, n + 6);
        expect_ev(2, 4'b0100, n + 7);
        wait_until(n + 7);
        btn_n = 4'b1111;
        expect_ev(0, 4'b0000, n + 13);

        // Key 2 press pulse coincides with consume: press wins.
        wait_until(n + 15);
        n = cyc;
        btn_n = 4'b1011;
        expect_ev(0, 4'b0100, n + 6);
        expect_ev(1, 4'b0100, n + 6);
        expect_ev(2, 4'b0110, n + 7);
        wait_until(n + 6);
        consume = 1'b1;
        @(negedge clk);
        consume = 1'b0;
        btn_n = 4'b1111;
        expect_ev(0, 4'b0000, n + 13);
        wait_until(n + 8);
        check_val("press_beats_consume", {1'b0, dir_valid, dir}, 4'b0110);

        // Consume, then a consume with nothing pending is ignored.
        wait_until(n + 15);
        consume_pulse(1'b1, 4'b0010);
        repeat (2) @(negedge clk);
        consume_pulse(1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        check_val("idle_consume_dir", {1'b0, dir_valid, dir}, 4'b0010);

        // Reset two cycles into a key 1 debounce restarts the window.
        n = cyc;
        btn_n = 4'b1101;
        wait_until(n + 4);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expect_ev(0, 4'b0010, n + 11);
        expect_ev(1, 4'b0010, n + 11);
        expect_ev(2, 4'b0101, n + 12);
        wait_until(n + 8);
        check_val("reset_mid_debounce_held", held, 4'b0000);
        wait_until(n + 12);
        btn_n = 4'b1111;
        expect_ev(0, 4'b0000, n + 18);
        wait_until(n + 13);
        consume_pulse(1'b1, 4'b0001);
        wait_until(n + 20);

`ifdef DIR_AUTO_REPEAT_EN
        // Key 1 held ~40 cycles: direction re-arms every 10 cycles.
        n = cyc;
        btn_n = 4'b1101;
        expect_ev(0, 4'b0010, n + 6);
        expect_ev(1, 4'b0010, n + 6);
        expect_ev(2, 4'b0101, n + 7);
        wait_until(n + 7);
        consume_pulse(1'b1, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            expect_ev(2, 4'b0101, n + 18 + 10 * k);
            wait_until(n + 18 + 10 * k);
            consume_pulse(1'b1, 4'b0001);
        end
        wait_until(n + 40);
        btn_n = 4'b1111;
        expect_ev(0, 4'b0000, n + 46);
        wait_until(n + 50);
`endif

        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty: got %0d pending events, required 0", exp_q.size());
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                $display("FAIL missing_%s: got nothing, required %b at cycle %0d",
                         kname(mon_e.kind), mon_e.val, mon_e.cyc);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
